// File: rtl/seq_decoder_pkg.sv
// seq_decoder_pkg: FSM state type and default configuration for seq_decoder.
package seq_decoder_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_DWELL = 1;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   onehot
);
  always_comb begin
    onehot = '0;
    onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/seq_decoder.sv
// seq_decoder: one-hot output selector with direct load and optional timed sweep.
// Sweep mode is compiled in only when SEQ_DECODER_SWEEP_EN is defined.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load_valid,
  input  logic [SEL_W-1:0]     load_sel,
  output logic                 load_ready,
  input  logic                 sweep_start,
  input  logic                 sweep_stop,
  output logic [2**SEL_W-1:0]  out,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 busy,
  output logic                 wrap_pulse
);
  localparam int OUT_W = 2**SEL_W;
  state_t state;
  logic [OUT_W-1:0] dec;
  onehot_dec #(.SEL_W(SEL_W)) u_dec (.sel(out_sel), .onehot(dec));
  assign out = (en && state != IDLE) ? dec : '0;
`ifdef SEQ_DECODER_SWEEP_EN
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  logic [7:0] dwell;
  assign load_ready = (state != SWEEP) && !sweep_start;
  assign busy = state == SWEEP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_sel <= '0;
      dwell <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (state == SWEEP && sweep_stop) begin
        state <= HOLD;
        dwell <= '0;
      end else if (state == SWEEP) begin
        if (dwell == DWELL_LAST) begin
          dwell <= '0;
          out_sel <= out_sel + 1'b1;
          wrap_pulse <= &out_sel;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end else if (sweep_start) begin
        state <= SWEEP;
        out_sel <= '0;
        dwell <= '0;
      end else if (load_valid && load_ready) begin
        state <= HOLD;
        out_sel <= load_sel;
      end
    end
  end
`else
  logic unused_sweep;
  assign unused_sweep = sweep_start ^ sweep_stop ^ (DWELL == 0);
  assign load_ready = state != SWEEP;
  assign busy = 1'b0;
  assign wrap_pulse = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_sel <= '0;
    end else if (load_valid && load_ready) begin
      state <= HOLD;
      out_sel <= load_sel;
    end
  end
`endif
endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: directed plus random checks of two seq_decoder configurations against a sweep-time model.
module tb_seq_decoder;
`ifdef SEQ_DECODER_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, en, load_valid, sweep_start, sweep_stop;
  logic [1:0] load_sel_a;
  logic [2:0] load_sel_b;
  logic load_ready_a, load_ready_b, busy_a, busy_b, wrap_a, wrap_b;
  logic [3:0] out_a;
  logic [7:0] out_b;
  logic [1:0] out_sel_a;
  logic [2:0] out_sel_b;
  int n_checks = 0;
  int n_errors = 0;
  int mode[2], sel[2], t[2];
  bit wr[2];
  int nw[2] = '{4, 8};
  int dw[2] = '{1, 3};

  always #5 clk = ~clk;

  seq_decoder #(.SEL_W(2), .DWELL(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_sel(load_sel_a),
    .load_ready(load_ready_a), .sweep_start(sweep_start), .sweep_stop(sweep_stop),
    .out(out_a), .out_sel(out_sel_a), .busy(busy_a), .wrap_pulse(wrap_a));

  seq_decoder #(.SEL_W(3), .DWELL(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_sel(load_sel_b),
    .load_ready(load_ready_b), .sweep_start(sweep_start), .sweep_stop(sweep_stop),
    .out(out_b), .out_sel(out_sel_b), .busy(busy_b), .wrap_pulse(wrap_b));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sweep position is derived from elapsed sweep cycles, not from a dwell counter.
  function automatic void step(int i, bit r, bit lv, int ls, bit ss, bit sp);
    wr[i] = 1'b0;
    if (r) begin
      mode[i] = 0; sel[i] = 0; t[i] = 0;
    end else if (SW && mode[i] == 2 && sp) begin
      mode[i] = 1;
    end else if (mode[i] == 2) begin
      t[i]++;
      sel[i] = (t[i] / dw[i]) % nw[i];
      wr[i] = (t[i] % (dw[i] * nw[i])) == 0;
    end else if (SW && ss) begin
      mode[i] = 2; t[i] = 0; sel[i] = 0;
    end else if (lv) begin
      mode[i] = 1; sel[i] = ls;
    end
  endfunction

  function automatic bit exp_ready(int i);
    return mode[i] != 2 && !(SW && sweep_start);
  endfunction

  function automatic logic [63:0] exp_out(int i);
    return (en && mode[i] != 0) ? (64'd1 << sel[i]) : 64'd0;
  endfunction

  task automatic drive(bit r, bit e, bit lv, int la, int lb, bit ss, bit sp);
    rst = r; en = e; load_valid = lv; sweep_start = ss; sweep_stop = sp;
    load_sel_a = la[1:0];
    load_sel_b = lb[2:0];
    #1;
    chk("ready_a", load_ready_a, exp_ready(0));
    chk("ready_b", load_ready_b, exp_ready(1));
    @(posedge clk);
    step(0, r, lv, la & 3, ss, sp);
    step(1, r, lv, lb & 7, ss, sp);
    #1;
    chk("out_a", out_a, exp_out(0));
    chk("sel_a", out_sel_a, sel[0]);
    chk("busy_a", busy_a, mode[0] == 2);
    chk("wrap_a", wrap_a, wr[0]);
    chk("out_b", out_b, exp_out(1));
    chk("sel_b", out_sel_b, sel[1]);
    chk("busy_b", busy_b, mode[1] == 2);
    chk("wrap_b", wrap_b, wr[1]);
  endtask

  initial begin
    int exp_seq[5] = '{1, 2, 4, 8, 1};
    int wraps;
    bit ss, sp;
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; sweep_start = 1'b0; sweep_stop = 1'b0;
    load_sel_a = '0; load_sel_b = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin mode[i] = 0; sel[i] = 0; t[i] = 0; wr[i] = 0; end
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_out", out_a, 0);
    chk("rst_ready", load_ready_a, 1);
    drive(0, 1, 1, 2, 5, 0, 0);
    chk("load_out", out_a, 4'b0100);
    chk("load_sel", out_sel_a, 2);
    chk("load_ready", load_ready_a, 1);
    chk("load_busy", busy_a, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0, 0, k == 0, 0);
      chk("sweep_seq", out_a, SW ? exp_seq[k] : 4);
      chk("sweep_wrap", wrap_a, SW && k == 4);
      chk("sweep_busy", busy_a, SW);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("stop_out", out_a, 4'b0100);
    chk("stop_ready", load_ready_a, 1);
    chk("stop_busy", busy_a, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 3, 3, 1, 0);
    chk("coll_out", out_a, SW ? 4'b0001 : 4'b1000);
    chk("coll_busy", busy_a, SW);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("en_out", out_a, 0);
    chk("en_sel", out_sel_a, SW ? 2 : 3);
    drive(1, 1, 1, 1, 1, 1, 1);
    chk("rst_sweep_out", out_a, 0);
    chk("rst_sweep_sel", out_sel_a, 0);
    chk("rst_sweep_busy", busy_a, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    wraps = 0;
    for (int k = 0; k < 50; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      wraps += int'(wrap_b);
    end
    chk("dwell_wraps", wraps, SW ? 2 : 0);
    for (int k = 0; k < 400; k++) begin
      ss = $urandom_range(0, 9) == 0;
      sp = !ss && $urandom_range(0, 9) == 0;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3), $urandom_range(0, 7), ss, sp);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 2: select width; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 1: cycles each output is held in sweep mode; legal range 1..255.
REQ-003 SHALL derive localparam OUT_W = 2**SEL_W, the one-hot output width.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: output enable; gates out only.
REQ-007 SHALL have port load_valid, input, 1: direct-select request.
REQ-008 SHALL have port load_sel, input, SEL_W: requested index.
REQ-009 SHALL have port load_ready, output, 1: a load is accepted this cycle if high.
REQ-010 SHALL have port sweep_start, input, 1: enter sweep mode.
REQ-011 SHALL have port sweep_stop, input, 1: leave sweep mode, holding the current index.
REQ-012 SHALL have port out, output, OUT_W: one-hot decode of out_sel, or all zero.
REQ-013 SHALL have port out_sel, output, SEL_W: registered current index.
REQ-014 SHALL have port busy, output, 1: high while in SWEEP.
REQ-015 SHALL have port wrap_pulse, output, 1: one-cycle pulse on sweep wrap.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, HOLD and SWEEP.
REQ-017 SHALL apply command priority per cycle: rst > sweep_stop > sweep_start > load.
REQ-018 SHALL drive load_ready = (state != SWEEP) && !sweep_start, combinationally.
REQ-019 SHALL accept a load when load_valid && load_ready: out_sel <= load_sel, state <= HOLD; out reflects it the next cycle (1-cycle latency).
REQ-020 SHALL go to SWEEP on sweep_start from IDLE or HOLD, with out_sel <= 0 and dwell counter <= 0; sweep_start in SWEEP is ignored.
REQ-021 SHALL, in SWEEP, count dwell 0..DWELL-1; at DWELL-1 the counter clears and out_sel increments modulo OUT_W.
REQ-022 SHALL register wrap_pulse high for exactly the cycle in which out_sel has just wrapped from OUT_W-1 to 0; it is low otherwise.
REQ-023 SHALL go to HOLD on sweep_stop in SWEEP, keeping out_sel and clearing the dwell counter; sweep_stop in IDLE or HOLD is ignored.
REQ-024 SHALL drive out = onehot(out_sel) when en && state != IDLE, else all zero; en is the only combinational input-to-out path.
REQ-025 SHALL keep state, out_sel and dwell advancing regardless of en.
REQ-026 SHALL allow a load in HOLD, which re-targets out_sel the same way as from IDLE.
REQ-027 SHALL not wrap dwell in the same cycle as wrap_pulse when DWELL=1; the sequence SHALL be 0,1,...,OUT_W-1,0 with no stall.

Reset
REQ-028 SHALL reset to state IDLE, out_sel 0, dwell 0, wrap_pulse 0; hence out 0, busy 0, load_ready 1.
REQ-029 SHALL let rst override any simultaneous command, including mid-sweep; the reset values are visible the cycle after rst is sampled.

Configuration
REQ-030 SHALL compile sweep mode in only when the macro SEQ_DECODER_SWEEP_EN is defined: SWEEP state, dwell counter and wrap logic are present.
REQ-031 SHALL, without SEQ_DECODER_SWEEP_EN: keep all ports; ignore sweep_start and sweep_stop; tie busy and wrap_pulse to 0; drive load_ready = (state != SWEEP) with no sweep_start term (effectively always 1); never enter SWEEP.

Structure
REQ-032 SHALL place the state typedef (IDLE/HOLD/SWEEP) and default SEL_W and DWELL constants in package seq_decoder_pkg.
REQ-033 SHALL implement the one-hot decode as combinational sub-module onehot_dec, parameterised by SEL_W, instantiated once.

Verification (SEL_W=2, DWELL=1 unless stated)
REQ-034 SHALL verify load: reset; en=1; load_valid=1, load_sel=2 -> next cycle out=0100, out_sel=2, load_ready=1, busy=0.
REQ-035 SHALL verify sweep: sweep_start one cycle -> out sequence 0001,0010,0100,1000,0001; wrap_pulse=1 only with the second 0001; busy=1 throughout.
REQ-036 SHALL verify dwell: SEL_W=3, DWELL=3 -> each one-hot value held 3 cycles; wrap_pulse every 24 cycles.
REQ-037 SHALL verify stop and collision: sweep_stop while out=0100 -> HOLD, out stays 0100, load_ready=1; in IDLE, load_valid(sel=3)+sweep_start together -> SWEEP, out=0001, load not taken.
REQ-038 SHALL verify enable and reset: en=0 mid-sweep -> out=0000 while out_sel keeps advancing; rst mid-sweep -> next cycle out=0000, out_sel=0, busy=0, wrap_pulse=0.
REQ-039 SHALL verify the build without SEQ_DECODER_SWEEP_EN: sweep_start pulses -> busy=0, out unchanged.
